// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/ripple_chunk_stage.sv
// One pipeline stage: ripples one CHUNK-bit slice and registers the running
// result, the stage carry and the still-unused operand bits.
module ripple_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic             next_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic             valid,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             ovf_q
);

  localparam int unsigned LSB = IDX * CHUNK;

  logic [CHUNK:0]   carry;
  logic [CHUNK-1:0] chunk_sum;
  logic [WIDTH-1:0] sum_next;
  logic             ready_c;

  // Bit-serial ripple across this stage's slice.
  always_comb begin
    carry     = '0;
    chunk_sum = '0;
    carry[0]  = carry_in;
    for (int k = 0; k < int'(CHUNK); k++) begin
      chunk_sum[k] = a_in[LSB+k] ^ b_in[LSB+k] ^ carry[k];
      carry[k+1]   = (a_in[LSB+k] & b_in[LSB+k]) |
                     (carry[k] & (a_in[LSB+k] ^ b_in[LSB+k]));
    end
  end

  // Upper sum bits arriving from earlier stages are still zero.
  always_comb begin
    sum_next = sum_in | (WIDTH'(chunk_sum) << LSB);
    ready_c  = !valid || next_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ready_c) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a_q     <= a_in;
        b_q     <= b_in;
        sum_q   <= sum_next;
        carry_q <= carry[CHUNK];
        ovf_q   <= carry[CHUNK] ^ carry[CHUNK-1];
      end
    end
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides;
// carry is registered between STAGES equal slices.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] final_sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [WIDTH-1:0]  a_pipe   [STAGES+1];
  logic [WIDTH-1:0]  b_pipe   [STAGES+1];
  logic [WIDTH-1:0]  sum_pipe [STAGES+1];
  logic              carry_pipe [STAGES+1];
  logic              ovf_pipe   [STAGES+1];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES:0]   ready;

  assign a_pipe[0]     = input_a;
  assign b_pipe[0]     = (sub == MODE_SUB) ? ~input_b : input_b;
  assign sum_pipe[0]   = '0;
  assign carry_pipe[0] = carry_in;
  assign ovf_pipe[0]   = 1'b0;

  // A stage may advance when it or any stage downstream of it is empty.
  assign ready[STAGES] = out_ready;
  for (genvar i = 0; i < int'(STAGES); i++) begin : g_ready
    assign ready[i] = out_ready | ~(&stage_valid[STAGES-1:i]);
  end

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    ripple_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (i)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid ((i == 0) ? in_valid : stage_valid[(i == 0) ? 0 : i-1]),
      .next_ready (ready[i+1]),
      .a_in       (a_pipe[i]),
      .b_in       (b_pipe[i]),
      .sum_in     (sum_pipe[i]),
      .carry_in   (carry_pipe[i]),
      .valid      (stage_valid[i]),
      .a_q        (a_pipe[i+1]),
      .b_q        (b_pipe[i+1]),
      .sum_q      (sum_pipe[i+1]),
      .carry_q    (carry_pipe[i+1]),
      .ovf_q      (ovf_pipe[i+1])
    );
  end

  assign in_ready  = ready[0];
  assign out_valid = stage_valid[STAGES-1];
  assign final_sum = sum_pipe[STAGES];
  assign carry_out = carry_pipe[STAGES];
  assign overflow  = ovf_pipe[STAGES];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench for pipelined_ripple_adder (32/4 main, 16/1 and 16/16 side configs).
module tb_pipelined_ripple_adder;

  localparam int unsigned W   = 32;
  localparam int unsigned STG = 4;
  localparam int unsigned WS  = 16;

  logic          clk;
  logic          rst_n;
  logic          iv, ir, ov, ordy, co, ovf;
  logic [W-1:0]  a, b, sum;
  logic          ci, sb;
  logic          iv_s, ordy_s;
  logic          ir_s1, ov_s1, co_s1, ovf_s1;
  logic          ir_s16, ov_s16, co_s16, ovf_s16;
  logic [WS-1:0] sum_s1, sum_s16;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic         vci[8];
  logic         vsb[8];

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
    .input_a(a), .input_b(b), .carry_in(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy), .final_sum(sum),
    .carry_out(co), .overflow(ovf)
  );

  pipelined_ripple_adder #(.WIDTH(WS), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s1),
    .input_a(a[WS-1:0]), .input_b(b[WS-1:0]), .carry_in(ci), .sub(sb),
    .out_valid(ov_s1), .out_ready(ordy_s), .final_sum(sum_s1),
    .carry_out(co_s1), .overflow(ovf_s1)
  );

  pipelined_ripple_adder #(.WIDTH(WS), .STAGES(16)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s16),
    .input_a(a[WS-1:0]), .input_b(b[WS-1:0]), .carry_in(ci), .sub(sb),
    .out_valid(ov_s16), .out_ready(ordy_s), .final_sum(sum_s16),
    .carry_out(co_s16), .overflow(ovf_s16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry_out, sum} from wide arithmetic and the sign rule.
  function automatic logic [33:0] golden(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic s);
    logic [31:0] yy;
    logic [32:0] r;
    logic        v;
    yy = s ? ~y : y;
    r  = 33'(x) + 33'(yy) + 33'(c);
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {v, r[32], r[31:0]};
  endfunction

  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic c, input logic s, input logic [31:0] es,
                        input logic eco, input logic eovf);
    int lat;
    @(negedge clk);
    a = x; b = y; ci = c; sb = s; iv = 1'b1; ordy = 1'b1;
    @(negedge clk);
    iv  = 1'b0;
    lat = 1;
    #1;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
      #1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(STG));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_co"},  64'(co),  64'(eco));
    check({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  // Streams n vectors, offering one every gap cycles, with out_ready low for stn cycles from st0.
  task automatic run_stream(input string tag, input int n, input int gap,
                            input int st0, input int stn);
    int          sent, rcvd, c, next_off, peak, infl;
    logic        held, hco, hovf;
    logic [31:0] hs;
    logic [33:0] g;
    sent = 0; rcvd = 0; c = 0; next_off = 0; peak = 0;
    held = 1'b0; hco = 1'b0; hovf = 1'b0; hs = '0;
    @(negedge clk);
    while (rcvd < n && c < 200) begin
      iv = (sent < n) && (c >= next_off);
      if (sent < n) begin
        a = va[sent]; b = vb[sent]; ci = vci[sent]; sb = vsb[sent];
      end
      ordy = !(c >= st0 && c < st0 + stn);
      #1;
      infl = sent - rcvd;
      if (infl > peak) peak = infl;
      check({tag, "_inrdy"}, 64'(ir), 64'(ordy || infl < int'(STG)));
      if (held)
        check({tag, "_hold"}, 64'({ov, co, ovf, sum}), 64'({1'b1, hco, hovf, hs}));
      held = ov && !ordy;
      hs = sum; hco = co; hovf = ovf;
      if (ov && ordy) begin
        g = golden(va[rcvd], vb[rcvd], vci[rcvd], vsb[rcvd]);
        check({tag, "_sum"}, 64'(sum), 64'(g[31:0]));
        check({tag, "_flags"}, 64'({ovf, co}), 64'({g[33], g[32]}));
        rcvd++;
      end
      if (iv && ir) begin
        sent++;
        next_off = c + gap;
      end
      @(negedge clk);
      c++;
    end
    iv = 1'b0;
    ordy = 1'b1;
    check({tag, "_count"}, 64'(rcvd), 64'(n));
    check({tag, "_peak"},  64'(peak), 64'(STG));
  endtask

  initial begin
    va[0] = 32'h1234_5678; vb[0] = 32'h1111_1111; vci[0] = 1'b0; vsb[0] = 1'b0;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vci[1] = 1'b0; vsb[1] = 1'b0;
    va[2] = 32'h0000_0000; vb[2] = 32'h0000_0001; vci[2] = 1'b1; vsb[2] = 1'b1;
    va[3] = 32'hDEAD_BEEF; vb[3] = 32'h0102_0304; vci[3] = 1'b1; vsb[3] = 1'b0;
    va[4] = 32'h8000_0000; vb[4] = 32'h0000_0001; vci[4] = 1'b1; vsb[4] = 1'b1;
    va[5] = 32'h0000_FFFF; vb[5] = 32'h0000_FFFF; vci[5] = 1'b0; vsb[5] = 1'b0;
    va[6] = 32'hFFFF_FFFF; vb[6] = 32'hFFFF_FFFF; vci[6] = 1'b1; vsb[6] = 1'b0;
    va[7] = 32'h1234_5678; vb[7] = 32'h1234_5678; vci[7] = 1'b1; vsb[7] = 1'b1;

    rst_n = 1'b0; iv = 1'b0; iv_s = 1'b0; ordy = 1'b1; ordy_s = 1'b1;
    a = '0; b = '0; ci = 1'b0; sb = 1'b0;

    #12;
    check("rst_outs", 64'({ov, co, ovf, sum}), 64'(0));
    check("rst_outs_s", 64'({ov_s1, ov_s16, sum_s1, sum_s16}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_inrdy", 64'({ir, ir_s1, ir_s16}), 64'(3'b111));

    // Wrap-around and latency across all three configurations.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; ci = 1'b0; sb = 1'b0;
    iv = 1'b1; iv_s = 1'b1; ordy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      iv = 1'b0; iv_s = 1'b0;
      #1;
      check("lat_main", 64'(ov), 64'(k == 4));
      check("lat_s1",   64'(ov_s1), 64'(k == 1));
      check("lat_s16",  64'(ov_s16), 64'(k == 16));
      if (k == 4)  check("wrap_main", 64'({ovf, co, sum}), 64'({1'b0, 1'b1, 32'h0}));
      if (k == 1)  check("wrap_s1",   64'({ovf_s1, co_s1, sum_s1}), 64'({1'b0, 1'b1, 16'h0}));
      if (k == 16) check("wrap_s16",  64'({ovf_s16, co_s16, sum_s16}), 64'({1'b0, 1'b1, 16'h0}));
    end

    single("sub5m7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single("ovfpos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single("subeq",  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);

    run_stream("b2b", 8, 1, 5, 3);
    run_stream("sparse", 6, 3, 4, 7);

    // Reset with beats in flight and one parked at the output.
    @(negedge clk);
    ordy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      iv = 1'b1; a = va[j]; b = vb[j]; ci = vci[j]; sb = vsb[j];
      @(negedge clk);
    end
    iv = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_ov", 64'({ov, sum}), 64'({1'b1, 32'h2345_6789}));
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 64'({ov, co, ovf, sum}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("post_rst_ov", 64'(ov), 64'(0));
      check("post_rst_inrdy", 64'(ir), 64'(1));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
